// File: rtl/pc_upstream_pkg.sv
// Shared types and constants for the PC upstream packer: field widths, stream codes,
// chunk-count helper and the packer state encoding.
package pc_upstream_pkg;

    localparam int unsigned NPCcodeDefault = 8;
    localparam int unsigned NPCdataDefault = 24;

    localparam logic [7:0] HB_CODE = 8'd13;
    localparam logic [7:0] SF_CODE = 8'd14;

    // Number of chunk_w-bit chunks needed to carry a w-bit producer word.
    function automatic int unsigned words_for_width(input int unsigned w,
                                                    input int unsigned chunk_w);
        return (w + chunk_w - 1) / chunk_w;
    endfunction

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

endpackage

// File: rtl/pc_upstream_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    int unsigned     j;
    logic [IdxW-1:0] j_idx;
    logic            found;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        found       = 1'b0;
        j           = 0;
        j_idx       = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                j     = (32'(ptr_i) + k) % N;
                j_idx = IdxW'(j);
                if (!found && req_i[j_idx]) begin
                    found        = 1'b1;
                    gnt_o[j_idx] = 1'b1;
                    gnt_idx_o    = j_idx;
                end
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/pc_upstream_arbiter.sv
// N-channel round-robin upstream packer: grants one producer word, then emits it as
// NWORDS code-tagged payload chunks, least-significant chunk first.
module pc_upstream_arbiter
    import pc_upstream_pkg::*;
#(
    parameter int unsigned           NCH     = 4,
    parameter int unsigned           NPCcode = NPCcodeDefault,
    parameter int unsigned           NPCdata = NPCdataDefault,
    parameter int unsigned           NIN     = 48,
    parameter logic [NCH*NPCcode-1:0] CODES  = {8'd16, 8'd15, SF_CODE, HB_CODE},
    parameter logic [NCH*4-1:0]      NWORDS  = {4'd2, 4'd2, 4'd2, 4'd2}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*NIN-1:0]   in_d,
    input  logic [NCH-1:0]       in_v,
    output logic [NCH-1:0]       in_a,
    input  logic [NCH-1:0]       ch_en,
    output logic [NPCcode-1:0]   out_code,
    output logic [NPCdata-1:0]   out_payload,
    output logic                 out_v,
    input  logic                 out_a,
    output logic                 busy
);

    localparam int unsigned IdxW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned MaxWords = words_for_width(NIN, NPCdata);
    localparam int unsigned StageW   = MaxWords * NPCdata;

    if (NCH < 2) begin : g_bad_nch
        $error("pc_upstream_arbiter: NCH must be at least 2");
    end
    for (genvar i = 0; i < NCH; i++) begin : g_chk_words
        if (NWORDS[i*4 +: 4] == 4'd0 || int'(NWORDS[i*4 +: 4]) > int'(MaxWords)) begin : g_bad
            $error("pc_upstream_arbiter: NWORDS field %0d out of range", i);
        end
    end

    state_e              state_q, state_d;
    logic                out_v_q, out_v_d;
    logic [NPCcode-1:0]  code_q, code_d;
    logic [NPCdata-1:0]  payload_q, payload_d;
    logic [StageW-1:0]   stage_q, stage_d;
    logic [3:0]          words_left_q, words_left_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;

    logic [NCH-1:0]      gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic                gnt_valid;
    logic [StageW-1:0]   chan_word;

    rr_arbiter #(
        .N (NCH)
    ) u_rr (
        .req_i       (in_v & ch_en),
        .ptr_i       (ptr_q),
        .en_i        (state_q == StIdle),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign chan_word = StageW'(in_d[gnt_idx*NIN +: NIN]);

    always_comb begin
        state_d      = state_q;
        out_v_d      = out_v_q;
        code_d       = code_q;
        payload_d    = payload_q;
        stage_d      = stage_q;
        words_left_d = words_left_q;
        ptr_d        = ptr_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    // Stage keeps only the not-yet-sent chunks; bits above NIN are zero.
                    payload_d    = chan_word[NPCdata-1:0];
                    stage_d      = chan_word >> NPCdata;
                    code_d       = CODES[gnt_idx*NPCcode +: NPCcode];
                    words_left_d = NWORDS[gnt_idx*4 +: 4];
                    ptr_d        = (gnt_idx == IdxW'(NCH - 1)) ? '0 : gnt_idx + IdxW'(1);
                    out_v_d      = 1'b1;
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (out_a) begin
                    if (words_left_q == 4'd1) begin
                        out_v_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        payload_d    = stage_q[NPCdata-1:0];
                        stage_d      = stage_q >> NPCdata;
                        words_left_d = words_left_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            out_v_q      <= 1'b0;
            code_q       <= '0;
            payload_q    <= '0;
            stage_q      <= '0;
            words_left_q <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_v_q      <= out_v_d;
            code_q       <= code_d;
            payload_q    <= payload_d;
            stage_q      <= stage_d;
            words_left_q <= words_left_d;
            ptr_q        <= ptr_d;
        end
    end

    assign in_a        = gnt;
    assign out_v       = out_v_q;
    assign out_code    = code_q;
    assign out_payload = payload_q;
    assign busy        = (state_q == StSend);

`ifndef SYNTHESIS
    a_out_stable: assert property (@(posedge clk) disable iff (!reset)
        out_v && !out_a |=> out_v && $stable(out_code) && $stable(out_payload));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(in_a));
    a_ack_idle_only: assert property (@(posedge clk) disable iff (!reset)
        (state_q != StIdle) |-> (in_a == '0));
`endif

endmodule

// File: tb/tb_pc_upstream_arbiter.sv
// Directed bench for pc_upstream_arbiter: a W=2 instance and a W=1 instance share stimulus.
module tb_pc_upstream_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [191:0] in_d;
    logic [3:0]   in_v;
    logic [3:0]   ch_en;
    logic         out_a;

    logic [3:0]   in_a, in_a1;
    logic [7:0]   out_code, out_code1;
    logic [23:0]  out_payload, out_payload1;
    logic         out_v, out_v1;
    logic         busy, busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_upstream_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .in_d        (in_d),
        .in_v        (in_v),
        .in_a        (in_a),
        .ch_en       (ch_en),
        .out_code    (out_code),
        .out_payload (out_payload),
        .out_v       (out_v),
        .out_a       (out_a),
        .busy        (busy)
    );

    pc_upstream_arbiter #(
        .NWORDS ({4'd1, 4'd1, 4'd1, 4'd1})
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_d        (in_d),
        .in_v        (in_v),
        .in_a        (in_a1),
        .ch_en       (ch_en),
        .out_code    (out_code1),
        .out_payload (out_payload1),
        .out_v       (out_v1),
        .out_a       (out_a),
        .busy        (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_v  = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [47:0] chan_word(input int k);
        return {24'hA00000 | 24'(k), 24'hB00000 | 24'(k)};
    endfunction

    int order[4] = '{0, 2, 3, 0};

    initial begin
        reset = 1'b0;
        in_d  = '0;
        in_v  = 4'b0000;
        ch_en = 4'b1111;
        out_a = 1'b0;
        tick();
        tick();
        check("rst_out_v", out_v, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_payload", out_payload, 0);
        check("rst_in_a", in_a, 0);
        check("rst_busy", busy, 0);
        check("rst_out_v_w1", out_v1, 0);
        reset = 1'b1;

        // Single word, two chunks, no stall
        in_d[47:0] = 48'h123456ABCDEF;
        in_v  = 4'b0001;
        out_a = 1'b1;
        #1 check("sw_ack", in_a, 4'b0001);
        tick();
        in_v = 4'b0000;
        check("sw_v0", out_v, 1);
        check("sw_code0", out_code, 8'd13);
        check("sw_chunk0", out_payload, 24'hABCDEF);
        check("sw_busy", busy, 1);
        check("sw_no_ack", in_a, 0);
        tick();
        check("sw_code1", out_code, 8'd13);
        check("sw_chunk1", out_payload, 24'h123456);
        tick();
        check("sw_bubble_v", out_v, 0);
        check("sw_bubble_busy", busy, 0);
        in_v = 4'b0001;
        #1 check("sw_reack", in_a, 4'b0001);
        in_v = 4'b0000;

        // Round-robin on the single-chunk instance
        do_reset();
        for (int k = 0; k < 4; k++) in_d[k*48 +: 48] = chan_word(k);
        in_v  = 4'b1111;
        ch_en = 4'b1111;
        out_a = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1 check($sformatf("rr_ack%0d", n), in_a1, 4'b0001 << (n % 4));
            tick();
            check($sformatf("rr_code%0d", n), out_code1, 8'(13 + n % 4));
            check($sformatf("rr_data%0d", n), out_payload1, 24'hB00000 | 24'(n % 4));
            tick();
            check($sformatf("rr_done%0d", n), out_v1, 0);
        end

        // Output backpressure during chunk 0
        do_reset();
        in_d[47:0] = 48'h123456ABCDEF;
        in_v  = 4'b0001;
        out_a = 1'b0;
        #1;
        tick();
        in_v = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("bp_data%0d", n), out_payload, 24'hABCDEF);
            check($sformatf("bp_code%0d", n), out_code, 8'd13);
            check($sformatf("bp_ack%0d", n), in_a, 0);
        end
        out_a = 1'b1;
        tick();
        check("bp_chunk1", out_payload, 24'h123456);
        tick();
        check("bp_next_ptr", in_a, 4'b0010);
        in_v = 4'b0000;

        // Enable masking, then re-enable channel 1
        do_reset();
        for (int k = 0; k < 4; k++) in_d[k*48 +: 48] = chan_word(k);
        in_v  = 4'b1111;
        ch_en = 4'b1101;
        out_a = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1 check($sformatf("en_ack%0d", n), in_a, 4'b0001 << order[n]);
            tick();
            check($sformatf("en_code%0d", n), out_code, 8'(13 + order[n]));
            tick();
            tick();
        end
        ch_en = 4'b1111;
        #1 check("en_reenable_ack", in_a, 4'b0010);
        tick();
        check("en_reenable_code", out_code, 8'd14);
        in_v = 4'b0000;
        tick();
        tick();

        // Zero-extended narrow producer on channel 2
        do_reset();
        in_d[2*48 +: 48] = 48'h001FFFFFFFFF;
        in_v = 4'b0100;
        #1 check("zx_ack", in_a, 4'b0100);
        tick();
        in_v = 4'b0000;
        check("zx_code", out_code, 8'd15);
        check("zx_chunk0", out_payload, 24'hFFFFFF);
        tick();
        check("zx_chunk1", out_payload, 24'h001FFF);
        tick();
        check("zx_done", out_v, 0);

        // Reset mid-packet drops the packet and restarts arbitration at channel 0
        do_reset();
        for (int k = 0; k < 4; k++) in_d[k*48 +: 48] = chan_word(k);
        in_v  = 4'b0010;
        out_a = 1'b1;
        #1;
        tick();
        in_v = 4'b0000;
        check("rm_code0", out_code, 8'd14);
        tick();
        check("rm_chunk1", out_payload, 24'hA00001);
        out_a = 1'b0;
        reset = 1'b0;
        #1;
        check("rm_async_v", out_v, 0);
        check("rm_async_busy", busy, 0);
        tick();
        tick();
        reset = 1'b1;
        out_a = 1'b1;
        in_v  = 4'b1111;
        #1 check("rm_restart_ack", in_a, 4'b0001);
        tick();
        in_v = 4'b0000;
        check("rm_restart_code", out_code, 8'd13);
        check("rm_restart_chunk0", out_payload, 24'hB00000);
        tick();
        check("rm_restart_chunk1", out_payload, 24'hA00000);
        tick();
        check("rm_restart_done", out_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
